// File: rtl/tiny_pkg.sv
// Shared definitions for the TINY pipeline front end.
//   INST_W        : instruction and PC width
//   PC_INC        : byte increment between sequential fetches
//   fetch_state_t : fetch FSM state, tracking the single outstanding memory request
//   fetch_entry_t : one prefetch queue entry {pc, inst}
package tiny_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,  // no request outstanding
        WAIT  = 2'd1,  // a request is outstanding and its data will be kept
        DRAIN = 2'd2   // a request is outstanding but its data is stale
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, inst} entries.
//   clk        : clock, all state on rising edge
//   clr        : synchronous active-high reset, empties the queue
//   flush      : synchronous flush, same effect as clr
//   push       : write push_entry at the tail this cycle
//   push_entry : entry to write
//   pop        : drop the head entry this cycle
//   count      : number of valid entries
//   empty      : count == 0
//   head       : entry at the head (undefined contents when empty)
module fetch_queue
    import tiny_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output fetch_entry_t     head
);

    fetch_entry_t     mem_q [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_en;
    logic             push_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QDEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // A push into a full queue is only legal when the head leaves in the same cycle.
    always_comb begin
        pop_en  = pop && (count_q != '0);
        push_en = push && ((count_q < CNT_W'(QDEPTH)) || pop_en);
    end

    always_ff @(posedge clk) begin
        if (clr || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop_en) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_en && !clr && !flush) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        count = count_q;
        empty = (count_q == '0);
        head  = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads, buffers returned instructions with
// their PCs in a prefetch queue, and presents the head to decode.
//   clk           : clock, all state on rising edge
//   clr           : synchronous active-high reset
//   imemReq       : one-cycle read request strobe
//   imemAddr      : byte address, valid with imemReq
//   imemValid     : read data return strobe
//   imemData      : instruction word, valid with imemValid
//   readInst      : instruction at queue head (0 when empty or in reset)
//   presentPC     : PC of readInst (0 when empty or in reset)
//   ldInst        : decode loads readInst this cycle (queue pop)
//   clrInst       : decode clears its instruction register this cycle
//   stall         : decode cannot accept, hold the head
//   isBranchTaken : redirect pulse, flushes queue and in-flight fetch
//   branchTarget  : redirect address, valid with isBranchTaken
module fetch_unit
    import tiny_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = 32'h0,
    parameter int unsigned       QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              clr,
    output logic              imemReq,
    output logic [INST_W-1:0] imemAddr,
    input  logic              imemValid,
    input  logic [INST_W-1:0] imemData,
    output logic [INST_W-1:0] readInst,
    output logic [INST_W-1:0] presentPC,
    output logic              ldInst,
    output logic              clrInst,
    input  logic              stall,
    input  logic              isBranchTaken,
    input  logic [INST_W-1:0] branchTarget
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    fetch_state_t      state_q;
    logic [INST_W-1:0] fetch_pc_q;
    logic [INST_W-1:0] req_pc_q;

    logic [CNT_W-1:0]  q_count;
    logic              q_empty;
    fetch_entry_t      q_head;
    fetch_entry_t      q_push_entry;
    logic              q_push;
    logic              pop;
    logic              issue;
    logic [CNT_W:0]    occ_after; // queue occupancy after this cycle's push and pop

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .clr        (clr),
        .flush      (isBranchTaken),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (pop),
        .count      (q_count),
        .empty      (q_empty),
        .head       (q_head)
    );

    always_comb begin
        pop     = !q_empty && !stall && !isBranchTaken && !clr;
        ldInst  = pop;
        clrInst = isBranchTaken | clr;

        occ_after = {1'b0, q_count} + (CNT_W + 1)'(1) - (CNT_W + 1)'(pop);

        issue = 1'b0;
        case (state_q)
            RUN:     issue = (q_count < CNT_W'(QDEPTH));
            WAIT:    issue = imemValid && (occ_after < (CNT_W + 1)'(QDEPTH));
            default: issue = 1'b0;
        endcase
        if (clr || isBranchTaken) begin
            issue = 1'b0;
        end

        imemReq  = issue;
        imemAddr = fetch_pc_q;

        q_push            = (state_q == WAIT) && imemValid && !isBranchTaken && !clr;
        q_push_entry.pc   = req_pc_q;
        q_push_entry.inst = imemData;

        if (q_empty || clr) begin
            readInst  = '0;
            presentPC = '0;
        end else begin
            readInst  = q_head.inst;
            presentPC = q_head.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            if (issue) begin
                req_pc_q   <= fetch_pc_q;
                fetch_pc_q <= fetch_pc_q + PC_INC;
            end
            // Redirect wins over the increment; issue is already suppressed.
            if (isBranchTaken) begin
                fetch_pc_q <= branchTarget;
            end

            case (state_q)
                RUN: begin
                    if (issue) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (isBranchTaken) begin
                        state_q <= imemValid ? RUN : DRAIN;
                    end else if (imemValid) begin
                        state_q <= issue ? WAIT : RUN;
                    end
                end
                DRAIN: begin
                    if (imemValid) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule
